clock_period_meter: RTL and testbench
=====================================

// Module: clock_period_meter
// PURPOSE
//  Measures a divided square wave and reports its period and high time in clk cycles.
//  This is the inverse of the clock divider: from the waveform it recovers the divider value.
//  It sits beside the game-tick divider and checks or telemeters the tick rate.
//  It also accepts any slow, asynchronous, 50%-style input.
// PARAMETERS
//  CNT_W        28             width of counters and of the period/high_time outputs
//  SYNC_STAGES  2              flops in the input synchronizer (minimum 2)
//  TIMEOUT      2**CNT_W-1     cycle count that, if reached without a rising edge, means stalled input
// PORTS
//  clk        in   1      system clock; the single clock domain
//  rst        in   1      asynchronous, active-high reset
//  en         in   1      measurement enable; low forces IDLE
//  sig_in     in   1      waveform under test (asynchronous to clk)
//  period     out  CNT_W  clk cycles between the last two rising edges
//  high_time  out  CNT_W  clk cycles from that rising edge to the following falling edge
//  valid      out  1      1-cycle pulse when period/high_time are updated
//  timeout    out  1      level; set on stall, cleared by the next valid
//  busy       out  1      high in ARM or MEASURE
// BEHAVIOUR
//  Reset (async, rst=1):
//   - all outputs 0, counter 0, synchronizer 0, state IDLE.
//  Input path and edge detect:
//   - sig_in passes through SYNC_STAGES flops; s = last stage; s_d = s delayed one cycle.
//   - rise = s & ~s_d; fall = ~s & s_d.
//  States:
//   - IDLE: en=1 -> ARM.
//   - ARM: wait for rise; ignore fall; rise -> MEASURE with cnt<=1 and seen_fall<=0.
//   - MEASURE, every cycle: cnt<=cnt+1.
//   - MEASURE, on fall: high_time_shadow<=cnt and seen_fall<=1.
//   - MEASURE, on rise with seen_fall=1: period<=cnt, high_time<=shadow, valid<=1,
//     timeout<=0, cnt<=1, seen_fall<=0; stay in MEASURE.
//   - MEASURE, on rise with seen_fall=0: impossible after sync; treat as stall.
//   - MEASURE, cnt==TIMEOUT before rise: timeout<=1, valid stays 0, state -> ARM.
//   - Constant-high input and constant-low input both end in timeout.
//  Enable:
//   - en=0 in any state -> IDLE next cycle; period/high_time/timeout hold; valid=0.
//   - Re-enable re-arms; the first valid arrives on the second rising edge after arming.
//  Latency: valid is high SYNC_STAGES+1 clk cycles after the clk edge that first samples sig_in high.
//  Arithmetic: unsigned. cnt never wraps; TIMEOUT bounds it below 2**CNT_W.
//  Register updates: period and high_time change only in the valid cycle.
//  Minimum measurable period: 2 cycles (1 low, 1 high).
// STRUCTURE
//  Shared package clk_meas_pkg holds:
//   - state encoding IDLE=2'd0, ARM=2'd1, MEASURE=2'd2;
//   - CNT_W default constant, reused by the divider instantiation.
//  One sub-module, sync_edge_detect (parameter SYNC_STAGES):
//   - async-reset synchronizer plus rise/fall pulse outputs.
//   - reusable for button inputs elsewhere in the game.
//  Top level contains the FSM, cnt, high_time shadow, and output registers.
// TESTING
//  Bench drives sig_in from the existing divider instance (same clk).
//  1. divider=10, en=1 -> from the 2nd rise on, each valid shows period=10, high_time=5; timeout=0.
//  2. divider=7 -> period=7, high_time=4 (3 low, 4 high); valid every 7 cycles.
//  3. divider=2 -> period=2, high_time=1, valid every other cycle;
//     divider=1 (constant high), TIMEOUT=64 -> timeout=1 after 64 counts, no valid.
//  4. sig_in stuck low after valid traffic, TIMEOUT=64 -> timeout rises, period holds last value;
//     restore divider=10 -> timeout clears on the next valid with period=10.
//  5. rst pulse mid-MEASURE (async, not clk-aligned) -> all outputs 0 at once;
//     after release, the first valid needs two rises.
//  6. en drop mid-period -> valid never fires and outputs hold;
//     re-enable -> busy=1; the first valid is on the 2nd rise with the correct period.

Source files
------------

// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock period meter and the game-tick divider.
package clk_meas_pkg;

  // Default counter width, reused by the divider instantiation.
  localparam int CNT_W_DEF = 28;

  // Measurement FSM state encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

endpackage

// File: rtl/clock_period_meter_if.sv
// Control, waveform input and measurement results of the clock period meter.
interface clock_period_meter_if
  import clk_meas_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic             busy;

  // Driver side: enables the meter, supplies the waveform, reads results.
  modport master (
    output en,
    output sig_in,
    input  period,
    input  high_time,
    input  valid,
    input  timeout,
    input  busy
  );

  // Meter side.
  modport slave (
    input  en,
    input  sig_in,
    output period,
    output high_time,
    output valid,
    output timeout,
    output busy
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level input, followed by
// registered single-cycle rise/fall pulses on the synchronized level.
// Usable for any slow asynchronous input (buttons, external ticks).
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise,
  output logic fall
);

  // Fewer than two flops is not a synchronizer; clamp silently.
  localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [N-1:0] sync_q, sync_d;
  logic         s_d_q, s_d_d;
  logic         rise_q, rise_d;
  logic         fall_q, fall_d;

  // Shift the input through the synchronizer and form edge pulses.
  always_comb begin
    sync_d = {sync_q[N-2:0], d_in};
    s_d_d  = sync_q[N-1];
    rise_d = sync_q[N-1] & ~s_d_q;
    fall_d = ~sync_q[N-1] & s_d_q;
  end

  // Synchronizer, delayed level and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s_d_q  <= s_d_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time (in clk cycles) of a slow square wave,
// recovering the divider value that produced it. Flags a stalled input
// when no complete period arrives within TIMEOUT cycles.
module clock_period_meter
  import clk_meas_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 2**CNT_W - 1
) (
  input  logic                 clk,
  input  logic                 rst,
  clock_period_meter_if.slave  bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic rise;
  logic fall;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             seen_fall_q, seen_fall_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d_in (bus.sig_in),
    .rise (rise),
    .fall (fall)
  );

  // Next-state, counter and result logic for the measurement FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    seen_fall_d = seen_fall_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    if (!bus.en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
        end
        ARM: begin
          // Falls are ignored here: a period is only timed from a rise.
          if (rise) begin
            state_d     = MEASURE;
            cnt_d       = ONE_C;
            seen_fall_d = 1'b0;
          end
        end
        MEASURE: begin
          if (rise && seen_fall_q) begin
            period_d    = cnt_q;
            high_time_d = shadow_q;
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
            cnt_d       = ONE_C;
            seen_fall_d = 1'b0;
          end else if (rise || (cnt_q == TIMEOUT_C)) begin
            // A rise without a preceding fall cannot come from a clean
            // synchronized waveform, so it is handled like a stall.
            timeout_d = 1'b1;
            state_d   = ARM;
          end else begin
            cnt_d = cnt_q + ONE_C;
            if (fall) begin
              shadow_d    = cnt_q;
              seen_fall_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      seen_fall_q <= 1'b0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      seen_fall_q <= seen_fall_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_time_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: a behavioural tick divider (or a
// manually driven level) feeds sig_in; results are compared against
// hand-computed period/high-time values.
module tb_clock_period_meter;
  import clk_meas_pkg::*;

  localparam int CNT_W = CNT_W_DEF;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  int   div_val = 10;
  int   dc      = 0;
  logic div_sig;
  logic use_div = 1'b0;
  logic man_sig = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  clock_period_meter_if #(.CNT_W(CNT_W)) bus ();

  clock_period_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2),
    .TIMEOUT     (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Tick divider: floor(div/2) cycles low, ceil(div/2) cycles high.
  always @(posedge clk) begin
    if (dc >= div_val - 1) dc <= 0;
    else                   dc <= dc + 1;
  end
  assign div_sig    = (dc >= div_val / 2);
  assign bus.sig_in = use_div ? div_sig : man_sig;
  assign bus.en     = en;

  typedef struct {
    int div;
    int exp_period;
    int exp_high;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int cycles, output bit got);
    got    = 1'b0;
    cycles = 0;
    while (cycles < budget && !got) begin
      @(negedge clk);
      cycles++;
      if (bus.valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic wait_timeout(input int budget, output bit got, output int nvalid);
    int cycles;
    got    = 1'b0;
    nvalid = 0;
    cycles = 0;
    while (cycles < budget && !got) begin
      @(negedge clk);
      cycles++;
      if (bus.valid === 1'b1) nvalid++;
      if (bus.timeout === 1'b1) got = 1'b1;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_period"},    bus.period,    0);
    check({tag, "_high_time"}, bus.high_time, 0);
    check({tag, "_valid"},     bus.valid,     0);
    check({tag, "_timeout"},   bus.timeout,   0);
    check({tag, "_busy"},      bus.busy,      0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  got;
    int  nv;

    vecs[0] = '{div: 10, exp_period: 10, exp_high: 5};
    vecs[1] = '{div: 7,  exp_period: 7,  exp_high: 4};
    vecs[2] = '{div: 2,  exp_period: 2,  exp_high: 1};
    vecs[3] = '{div: 3,  exp_period: 3,  exp_high: 2};

    // Reset state
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    en  = 1'b1;
    repeat (4) @(negedge clk);
    check("arm_busy", bus.busy, 1);
    check("arm_no_valid", bus.valid, 0);

    // Manual waveform: 3 high, 3 low, then high; valid 3 cycles after sampling
    man_sig = 1'b1;
    repeat (3) @(negedge clk);
    man_sig = 1'b0;
    repeat (3) @(negedge clk);
    man_sig = 1'b1;
    repeat (3) @(negedge clk);
    check("lat_early_valid", bus.valid, 0);
    @(negedge clk);
    check("lat_valid", bus.valid, 1);
    check("lat_period", bus.period, 6);
    check("lat_high_time", bus.high_time, 3);

    // Table-driven divider values
    use_div = 1'b1;
    for (int i = 0; i < 4; i++) begin
      div_val = vecs[i].div;
      for (int f = 0; f < 2; f++) begin
        wait_valid(4 * vecs[i].div + 20, cyc, got);
      end
      check($sformatf("v%0d_flush", i), got, 1);
      for (int k = 0; k < 4; k++) begin
        wait_valid(4 * vecs[i].div + 20, cyc, got);
        check($sformatf("v%0d_%0d_got", i, k), got, 1);
        check($sformatf("v%0d_%0d_period", i, k), bus.period, vecs[i].exp_period);
        check($sformatf("v%0d_%0d_high", i, k), bus.high_time, vecs[i].exp_high);
        check($sformatf("v%0d_%0d_interval", i, k), cyc, vecs[i].exp_period);
        check($sformatf("v%0d_%0d_timeout", i, k), bus.timeout, 0);
      end
    end

    // Constant-high input (divider 1) ends in timeout with no further valid
    div_val = 1;
    wait_timeout(300, got, nv);
    check("const_high_timeout", got, 1);
    nv = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.valid === 1'b1) nv++;
    end
    check("const_high_no_valid", nv, 0);
    check("const_high_timeout_held", bus.timeout, 1);
    check("const_high_busy", bus.busy, 1);

    // Back to divider 10: first valid clears timeout with a full period
    div_val = 10;
    wait_valid(60, cyc, got);
    check("recover_got", got, 1);
    check("recover_period", bus.period, 10);
    check("recover_high", bus.high_time, 5);
    check("recover_timeout", bus.timeout, 0);

    // Stuck low after traffic: timeout rises, results hold
    use_div = 1'b0;
    man_sig = 1'b0;
    wait_timeout(150, got, nv);
    check("stuck_low_timeout", got, 1);
    check("stuck_low_no_valid", nv, 0);
    check("stuck_low_period_hold", bus.period, 10);
    check("stuck_low_high_hold", bus.high_time, 5);

    // Restore divider: timeout clears on the next valid
    use_div = 1'b1;
    wait_valid(60, cyc, got);
    check("restore_got", got, 1);
    check("restore_timeout", bus.timeout, 0);
    check("restore_period", bus.period, 10);

    // Asynchronous reset mid-MEASURE
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    @(negedge clk);
    use_div = 1'b0;
    man_sig = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Exact timeout: rise then fall, no second rise; timeout after 64 counts
    man_sig = 1'b1;
    repeat (2) @(negedge clk);
    man_sig = 1'b0;
    repeat (65) @(negedge clk);
    check("tmo_before", bus.timeout, 0);
    @(negedge clk);
    check("tmo_at", bus.timeout, 1);
    check("tmo_no_valid", bus.valid, 0);
    check("tmo_busy", bus.busy, 1);

    // After reset, the first valid still needs two rises
    use_div = 1'b1;
    wait_valid(60, cyc, got);
    check("post_rst_got", got, 1);
    check("post_rst_period", bus.period, 10);
    check("post_rst_high", bus.high_time, 5);

    // Enable drop mid-period: outputs hold, no valid, busy low
    repeat (3) @(negedge clk);
    en = 1'b0;
    nv = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.valid === 1'b1) nv++;
    end
    check("en_off_no_valid", nv, 0);
    check("en_off_busy", bus.busy, 0);
    check("en_off_period_hold", bus.period, 10);
    check("en_off_high_hold", bus.high_time, 5);
    check("en_off_timeout_hold", bus.timeout, 0);

    // Re-enable: busy returns, first valid reports the correct period
    en = 1'b1;
    @(negedge clk);
    check("reen_busy", bus.busy, 1);
    wait_valid(60, cyc, got);
    check("reen_got", got, 1);
    check("reen_period", bus.period, 10);
    check("reen_high", bus.high_time, 5);
    wait_valid(30, cyc, got);
    check("reen_interval", cyc, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
